// File: rtl/rr_grant_scheduler_16_if.sv
// Handshake bundle between the 16 requesters, the shared resource and the
// round-robin grant scheduler. The master side drives requests and completion.
// The slave side (the scheduler) drives the grant outputs.
interface rr_grant_scheduler_16_if;
    logic [15:0] req;
    logic        done;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        busy;
    logic        timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_grant_scheduler_16.sv
// Round-robin grant scheduler for 16 requesters sharing one resource.
// The FSM has two states. IDLE picks the next requester at or above rr_ptr,
// wrapping from 15 to 0. OWN holds that grant until one of three events:
// the resource reports done, the owner drops its request, or the hold limit
// is reached. Only the hold-limit case raises a one-cycle timeout pulse.
// There is always at least one IDLE cycle between two grants.
module rr_grant_scheduler_16 #(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    rr_grant_scheduler_16_if.slave bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0]  state_reg;
    logic [15:0] grant_reg;
    logic [3:0]  grant_idx_reg;
    logic [7:0]  hold_cnt_reg;
    logic [3:0]  rr_ptr_reg;
    logic        timeout_reg;

    // Requests rotated so that bit 0 is the requester at rr_ptr.
    logic [15:0] req_rot;
    logic [3:0]  sel_off;
    logic        sel_found;
    logic [3:0]  sel_idx;

    logic        owner_req;
    logic        hold_hit;
    logic        release_now;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rot
            assign req_rot[gi] = bus.req[rr_ptr_reg + 4'(gi)];
        end
    endgenerate

    // Find the lowest set rotated bit, which is the first requester at or above rr_ptr.
    always_comb begin
        sel_off   = 4'd0;
        sel_found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (req_rot[i]) begin
                sel_off   = 4'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign sel_idx     = rr_ptr_reg + sel_off;
    assign owner_req   = bus.req[grant_idx_reg];
    assign hold_hit    = (hold_cnt_reg == HOLD_LAST);
    assign release_now = bus.done || !owner_req || hold_hit;

    // State, grant, hold counter and round-robin pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= 16'h0000;
            grant_idx_reg <= 4'd0;
            hold_cnt_reg  <= 8'd0;
            rr_ptr_reg    <= 4'd0;
            timeout_reg   <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // A done seen in IDLE has no owner to apply to, so it is ignored.
                    if (sel_found) begin
                        state_reg     <= ST_OWN;
                        grant_reg     <= 16'h0001 << sel_idx;
                        grant_idx_reg <= sel_idx;
                        hold_cnt_reg  <= 8'd0;
                    end
                end
                ST_OWN: begin
                    if (release_now) begin
                        state_reg   <= ST_IDLE;
                        grant_reg   <= 16'h0000;
                        rr_ptr_reg  <= grant_idx_reg + 4'd1;
                        // Timeout only when the hold limit is the only reason to release.
                        timeout_reg <= hold_hit && !bus.done && owner_req;
                    end else if (!hold_hit) begin
                        hold_cnt_reg <= hold_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    grant_reg <= 16'h0000;
                end
            endcase
        end
    end

    assign bus.grant     = grant_reg;
    assign bus.grant_idx = grant_idx_reg;
    assign bus.busy      = |grant_reg;
    assign bus.timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_grant_scheduler_16.sv
// Directed testbench for rr_grant_scheduler_16. The DUT is built with
// MAX_HOLD=4 so that the hold-limit cases can be reached in a few cycles.
// Inputs change 1 ns after each rising edge, and the outputs are checked at
// that same point.
module tb_rr_grant_scheduler_16;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    rr_grant_scheduler_16_if bus ();

    rr_grant_scheduler_16 #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.req  = 16'h0000;
        bus.done = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        bus.req  = 16'hFFFF;
        bus.done = 1'b0;
        step();
        step();
        n_tests++;
        if ({bus.grant, bus.grant_idx, bus.busy, bus.timeout} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_state: got grant=%h idx=%0d busy=%b to=%b expected all zero",
                     bus.grant, bus.grant_idx, bus.busy, bus.timeout);
        end
        rst     = 1'b0;
        bus.req = 16'h0000;
        $display("[TB] test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 16'h0001;
        step();
        n_tests++;
        if (bus.grant !== 16'h0001 || bus.grant_idx !== 4'd0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got grant=%h idx=%0d busy=%b expected 0001/0/1",
                     bus.grant, bus.grant_idx, bus.busy);
        end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        n_tests++;
        if (bus.grant !== 16'h0000 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: got grant=%h busy=%b to=%b expected 0000/0/0",
                     bus.grant, bus.busy, bus.timeout);
        end
        $display("[TB] test_single done");
    endtask

    task automatic test_rotation();
        logic [3:0] exp_idx;
        do_reset();
        bus.req = 16'hFFFF;
        for (int k = 0; k < 17; k++) begin
            exp_idx = 4'(k % 16);
            step();
            n_tests++;
            if (bus.grant_idx !== exp_idx || bus.grant !== (16'h0001 << exp_idx)) begin
                n_fail++;
                $display("FAIL rotation_grant: got idx=%0d grant=%h expected idx=%0d",
                         bus.grant_idx, bus.grant, exp_idx);
            end
            bus.done = 1'b1;
            step();
            bus.done = 1'b0;
            n_tests++;
            if (bus.grant !== 16'h0000 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rotation_idle: got grant=%h busy=%b expected 0000/0",
                         bus.grant, bus.busy);
            end
            $display("[TB] rotation grant %0d idx=%0d", k, bus.grant_idx);
        end
    endtask

    task automatic test_wrap_and_skip();
        // Owner 15 releases, and then requester 0 wins after the pointer wraps.
        do_reset();
        bus.req = 16'h8000;
        step();
        n_tests++;
        if (bus.grant_idx !== 4'd15) begin
            n_fail++;
            $display("FAIL wrap_owner: got idx=%0d expected 15", bus.grant_idx);
        end
        bus.req  = 16'h8001;
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        step();
        n_tests++;
        if (bus.grant_idx !== 4'd0 || bus.grant !== 16'h0001) begin
            n_fail++;
            $display("FAIL wrap_next: got idx=%0d grant=%h expected 0/0001",
                     bus.grant_idx, bus.grant);
        end
        // Owner 2 releases with rr_ptr=3. Bit 2 is then skipped and the search wraps to 0.
        do_reset();
        bus.req = 16'h0004;
        step();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 16'h0005;
        step();
        n_tests++;
        if (bus.grant_idx !== 4'd0 || bus.grant !== 16'h0001) begin
            n_fail++;
            $display("FAIL skip_next: got idx=%0d grant=%h expected 0/0001",
                     bus.grant_idx, bus.grant);
        end
        $display("[TB] test_wrap_and_skip done");
    endtask

    task automatic test_hold_limit();
        do_reset();
        bus.req = 16'h0011;
        for (int c = 0; c < 4; c++) begin
            step();
            // Requests from other requesters must not disturb the current owner.
            if (c == 1) bus.req = 16'h0031;
            n_tests++;
            if (bus.grant !== 16'h0001 || bus.timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got grant=%h to=%b expected 0001/0",
                         c, bus.grant, bus.timeout);
            end
        end
        bus.req = 16'h0011;
        step();
        n_tests++;
        if (bus.grant !== 16'h0000 || bus.timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_timeout: got grant=%h to=%b expected 0000/1",
                     bus.grant, bus.timeout);
        end
        step();
        n_tests++;
        if (bus.grant_idx !== 4'd4 || bus.grant !== 16'h0010 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_next: got idx=%0d grant=%h to=%b expected 4/0010/0",
                     bus.grant_idx, bus.grant, bus.timeout);
        end
        $display("[TB] test_hold_limit done");
    endtask

    task automatic test_tie_and_drop();
        // done arrives in the same cycle as the hold limit, so there is no timeout.
        do_reset();
        bus.req = 16'h0011;
        for (int c = 0; c < 4; c++) step();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        n_tests++;
        if (bus.grant !== 16'h0000 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_release: got grant=%h to=%b expected 0000/0",
                     bus.grant, bus.timeout);
        end
        // The owner drops its request, which releases the grant without a timeout.
        do_reset();
        bus.req = 16'h0002;
        step();
        bus.req = 16'h0000;
        step();
        n_tests++;
        if (bus.grant !== 16'h0000 || bus.timeout !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_release: got grant=%h to=%b busy=%b expected 0000/0/0",
                     bus.grant, bus.timeout, bus.busy);
        end
        $display("[TB] test_tie_and_drop done");
    endtask

    task automatic test_idle_done();
        do_reset();
        bus.done = 1'b1;
        step();
        n_tests++;
        if (bus.grant !== 16'h0000 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done: got grant=%h to=%b expected 0000/0",
                     bus.grant, bus.timeout);
        end
        bus.req = 16'h0008;
        step();
        n_tests++;
        if (bus.grant !== 16'h0008 || bus.grant_idx !== 4'd3) begin
            n_fail++;
            $display("FAIL idle_done_grant: got grant=%h idx=%0d expected 0008/3",
                     bus.grant, bus.grant_idx);
        end
        bus.done = 1'b0;
        $display("[TB] test_idle_done done");
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 16'h0400;
        step();
        n_tests++;
        if (bus.grant !== 16'h0400) begin
            n_fail++;
            $display("FAIL async_setup: got grant=%h expected 0400", bus.grant);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.grant !== 16'h0000 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear: got grant=%h busy=%b to=%b expected 0000/0/0",
                     bus.grant, bus.busy, bus.timeout);
        end
        #1;
        rst     = 1'b0;
        bus.req = 16'hFFFF;
        step();
        n_tests++;
        if (bus.grant_idx !== 4'd0 || bus.grant !== 16'h0001) begin
            n_fail++;
            $display("FAIL async_restart: got idx=%0d grant=%h expected 0/0001",
                     bus.grant_idx, bus.grant);
        end
        $display("[TB] test_async_reset done");
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.req  = 16'h0000;
        bus.done = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_wrap_and_skip();
        test_hold_limit();
        test_tie_and_drop();
        test_idle_done();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
